// File: rtl/rx_burst_sched_if.sv
// rx_burst_sched_if: bundles the scheduler's control inputs, both receiver channel
// handshakes, the output Valid/Ready/Last stream and the status outputs.
//   master modport: the environment side (drives control, channel data, OutReady)
//   slave modport : the scheduler side (drives channel grants, stream, status)
// Signals:
//   Start, Stop, BurstLen[BURST_W], ChanMask[2]      control
//   Ch0Dat[32], Ch0Valid, Ch0Ready                   receiver channel 0
//   Ch1Dat[32], Ch1Valid, Ch1Ready                   receiver channel 1
//   OutDat[32], OutValid, OutLast, OutReady          output stream
//   Busy, Overrun, DropCnt[16]                       status
interface rx_burst_sched_if #(
    parameter int unsigned BURST_W = 12
);
    logic               Start;
    logic               Stop;
    logic [BURST_W-1:0] BurstLen;
    logic [1:0]         ChanMask;
    logic [31:0]        Ch0Dat;
    logic               Ch0Valid;
    logic               Ch0Ready;
    logic [31:0]        Ch1Dat;
    logic               Ch1Valid;
    logic               Ch1Ready;
    logic [31:0]        OutDat;
    logic               OutValid;
    logic               OutLast;
    logic               OutReady;
    logic               Busy;
    logic               Overrun;
    logic [15:0]        DropCnt;

    modport master (
        output Start, Stop, BurstLen, ChanMask, Ch0Dat, Ch0Valid, Ch1Dat, Ch1Valid, OutReady,
        input  Ch0Ready, Ch1Ready, OutDat, OutValid, OutLast, Busy, Overrun, DropCnt
    );

    modport slave (
        input  Start, Stop, BurstLen, ChanMask, Ch0Dat, Ch0Valid, Ch1Dat, Ch1Valid, OutReady,
        output Ch0Ready, Ch1Ready, OutDat, OutValid, OutLast, Busy, Overrun, DropCnt
    );
endinterface

// File: rtl/rx_burst_sched.sv
// rx_burst_sched: grants one RX demux channel at a time, collects a fixed-length burst of
// 32-bit samples from it, prefixes a header word {A5, 7'd0, ch, seq} and streams the result
// through a 4-entry first-word-fall-through buffer with Valid/Ready/Last.
// Ports:
//   Clk   : RxClk2 (61.44 MHz)
//   Reset : synchronous, active-high
//   bus   : rx_burst_sched_if.slave (control, channel handshakes, output stream, status)
// Optional feature macro RX_BURST_TIMESTAMP_EN: adds a free-running 32-bit timestamp and a
// second header word carrying the timestamp captured on HDR entry.
module rx_burst_sched #(
    parameter int unsigned BURST_W       = 12,
    parameter int unsigned DEFAULT_BURST = 256,
    parameter int unsigned SEQ_W         = 16
) (
    input logic             Clk,
    input logic             Reset,
    rx_burst_sched_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StSel, StHdr, StBurst, StDrain} state_e;

    localparam int unsigned Depth = 4;

    state_e             state_q, state_d;
    logic               ch_q;          // channel being served
    logic               rr_q;          // channel preferred at the next SEL
    logic [BURST_W-1:0] len_q;
    logic [BURST_W-1:0] cnt_q;         // accepted samples in this burst
    logic [SEQ_W-1:0]   seq_q;
    logic               stop_pend_q;
    logic               overrun_q;
    logic [15:0]        drop_cnt_q;

    logic [32:0]        mem_q [Depth];
    logic [1:0]         wr_ptr_q, rd_ptr_q;
    logic [2:0]         fill_q;

    logic               sel_valid;
    logic [31:0]        sel_dat;
    logic               accept;
    logic [BURST_W-1:0] cnt_inc, cnt_next;
    logic               last_sample;
    logic               full, empty, pop, push, drop;
    logic               hdr_push, hdr_done, seq_inc;
    logic [31:0]        hdr_word;
    logic [32:0]        push_word;
    logic               pick;
    logic [BURST_W-1:0] len_sel;

    // Round robin: keep the preferred channel if enabled, otherwise the other one.
    assign pick    = bus.ChanMask[rr_q] ? rr_q : ~rr_q;
    assign len_sel = (bus.BurstLen == '0) ? BURST_W'(DEFAULT_BURST) : bus.BurstLen;

    assign sel_valid   = ch_q ? bus.Ch1Valid : bus.Ch0Valid;
    assign sel_dat     = ch_q ? bus.Ch1Dat : bus.Ch0Dat;
    // Samples beyond len (late arrivals) are neither stored nor counted as drops.
    assign accept      = sel_valid && ((state_q == StBurst) || (state_q == StDrain)) &&
                         (cnt_q < len_q);
    assign cnt_inc     = cnt_q + BURST_W'(1);
    assign cnt_next    = accept ? cnt_inc : cnt_q;
    assign last_sample = accept && (cnt_inc == len_q);

    assign full  = (fill_q == 3'(Depth));
    assign empty = (fill_q == 3'd0);
    assign pop   = !empty && bus.OutReady;

`ifdef RX_BURST_TIMESTAMP_EN
    logic [31:0] ts_q, ts_hdr_q;
    logic        hdr_second_q;     // first header word already pushed
    logic        hdr_push_first;

    // Both header words need room before the first is written.
    assign hdr_push_first = (state_q == StHdr) && !hdr_second_q && (fill_q <= 3'd2);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ts_q         <= '0;
            ts_hdr_q     <= '0;
            hdr_second_q <= 1'b0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if ((state_q == StSel) && (state_d == StHdr)) begin
                ts_hdr_q <= ts_q + 32'd1;
            end
            if (hdr_push_first) begin
                hdr_second_q <= 1'b1;
            end else if (hdr_done) begin
                hdr_second_q <= 1'b0;
            end
        end
    end
`endif

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // Stop wins over a simultaneous Start.
                if (bus.Start && !bus.Stop && (bus.ChanMask != 2'b00)) begin
                    state_d = StSel;
                end
            end
            StSel: begin
                state_d = (bus.ChanMask == 2'b00) ? StIdle : StHdr;
            end
            StHdr: begin
                if (hdr_done) begin
                    state_d = StBurst;
                end
            end
            StBurst: begin
                // One-cycle Ready-to-Valid latency: drop Ready once len-1 samples are in.
                if (cnt_next >= (len_q - BURST_W'(1))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (cnt_next == len_q) begin
                    state_d = (stop_pend_q || bus.Stop) ? StIdle : StSel;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.Ch0Ready = (state_q == StBurst) && !ch_q;
        bus.Ch1Ready = (state_q == StBurst) && ch_q;
`ifdef RX_BURST_TIMESTAMP_EN
        hdr_done = (state_q == StHdr) && hdr_second_q;
        hdr_push = hdr_push_first || hdr_done;
        seq_inc  = hdr_push_first;
        hdr_word = hdr_second_q ? ts_hdr_q : {8'hA5, 7'd0, ch_q, seq_q};
`else
        hdr_push = (state_q == StHdr) && !full;
        hdr_done = hdr_push;
        seq_inc  = hdr_push;
        hdr_word = {8'hA5, 7'd0, ch_q, seq_q};
`endif
    end

    // Header and sample pushes never coincide (HDR vs BURST/DRAIN).
    assign push_word = hdr_push ? {1'b0, hdr_word} : {last_sample, sel_dat};
    assign push      = (hdr_push || accept) && (!full || pop);
    assign drop      = accept && full && !pop;

    // Burst bookkeeping, buffer pointers and status
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ch_q        <= 1'b0;
            rr_q        <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            seq_q       <= '0;
            stop_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
            drop_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
        end else begin
            if ((state_q == StSel) && (bus.ChanMask != 2'b00)) begin
                ch_q  <= pick;
                rr_q  <= ~pick;
                len_q <= len_sel;
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_inc;
            end

            if (seq_inc) begin
                seq_q <= seq_q + SEQ_W'(1);
            end

            if (state_q == StIdle) begin
                stop_pend_q <= 1'b0;
            end else if (bus.Stop) begin
                stop_pend_q <= 1'b1;
            end

            if (drop) begin
                overrun_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            fill_q <= fill_q + 3'(push) - 3'(pop);
        end
    end

    // Buffer storage needs no reset: reads are gated by the fill count.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign bus.OutValid = !empty;
    assign bus.OutDat   = empty ? 32'd0 : mem_q[rd_ptr_q][31:0];
    assign bus.OutLast  = empty ? 1'b0 : mem_q[rd_ptr_q][32];
    assign bus.Busy     = (state_q != StIdle) || !empty;
    assign bus.Overrun  = overrun_q;
    assign bus.DropCnt  = drop_cnt_q;
endmodule

// File: tb/tb_rx_burst_sched.sv
// tb_rx_burst_sched: directed bench for rx_burst_sched. Two channel sources answer Ready
// with Valid one cycle later (ch0 data 0x1000_0000+n, ch1 data 0x2000_0000+n); a monitor
// records every popped output word for the directed checks.
module tb_rx_burst_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rx_burst_sched_if #(.BURST_W(12)) bus ();

    rx_burst_sched #(
        .BURST_W      (12),
        .DEFAULT_BURST(256),
        .SEQ_W        (16)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    int unsigned c0_n = 0, c1_n = 0, rdy0_cnt = 0, rdy1_cnt = 0;
    logic        r0 = 1'b0, r1 = 1'b0;

    // Channel sources: Valid follows Ready by one cycle, one fresh sample per Valid.
    always @(negedge clk) begin
        if (rst) begin
            c0_n = 0;
            c1_n = 0;
            r0 = 1'b0;
            r1 = 1'b0;
            bus.Ch0Valid = 1'b0;
            bus.Ch1Valid = 1'b0;
            bus.Ch0Dat = 32'd0;
            bus.Ch1Dat = 32'd0;
        end else begin
            bus.Ch0Valid = r0;
            if (r0) begin
                bus.Ch0Dat = 32'h1000_0000 + 32'(c0_n);
                c0_n++;
            end
            bus.Ch1Valid = r1;
            if (r1) begin
                bus.Ch1Dat = 32'h2000_0000 + 32'(c1_n);
                c1_n++;
            end
            r0 = bus.Ch0Ready;
            r1 = bus.Ch1Ready;
            if (bus.Ch0Ready) rdy0_cnt++;
            if (bus.Ch1Ready) rdy1_cnt++;
        end
    end

    logic [32:0] out_mem [1024];
    int unsigned out_wr = 0;

    always @(negedge clk) begin
        if (bus.OutValid && bus.OutReady) begin
            out_mem[out_wr % 1024] = {bus.OutLast, bus.OutDat};
            out_wr++;
        end
    end

    int unsigned n_cmp = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.Stop = 1'b1;
        tick();
        bus.Stop = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned budget, input string tag);
        int unsigned k = 0;
        while (bus.Busy && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(bus.Busy), 64'd0);
    endtask

    task automatic wait_words(input int unsigned b, input int unsigned n,
                              input int unsigned budget, input string tag);
        int unsigned k = 0;
        while ((out_wr - b) < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'((out_wr - b) >= n), 64'd1);
    endtask

    function automatic logic [32:0] word(input int unsigned b, input int unsigned i);
        return out_mem[(b + i) % 1024];
    endfunction

    function automatic logic [63:0] hdr(input logic ch, input logic [15:0] seq);
        return 64'({1'b0, 8'hA5, 7'd0, ch, seq});
    endfunction

    function automatic logic [63:0] smp(input logic last, input logic [31:0] d);
        return 64'({last, d});
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({bus.OutValid, bus.OutLast, bus.OutDat, bus.Ch0Ready, bus.Ch1Ready,
                    bus.Busy, bus.Overrun, bus.DropCnt});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned base, r0s, r1s, nw, nb, snap;
        rst = 1'b1;
        bus.Start = 1'b0;
        bus.Stop = 1'b0;
        bus.BurstLen = 12'd0;
        bus.ChanMask = 2'b00;
        bus.OutReady = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_outputs", all_outs(), 64'd0);

        // Single channel, burst of 4
        bus.ChanMask = 2'b01;
        bus.BurstLen = 12'd4;
        base = out_wr;
        r1s = rdy1_cnt;
        pulse_start();
        pulse_stop();
        wait_idle(100, "t1_idle");
        check("t1_count", 64'(out_wr - base), 64'd5);
        check("t1_hdr", 64'(word(base, 0)), hdr(1'b0, 16'd0));
        for (int i = 0; i < 4; i++) begin
            check("t1_sample", 64'(word(base, i + 1)), smp(i == 3, 32'h1000_0000 + 32'(i)));
        end
        check("t1_ch1_ready", 64'(rdy1_cnt - r1s), 64'd0);

        // Two channels alternate, burst of 2
        do_reset();
        bus.ChanMask = 2'b11;
        bus.BurstLen = 12'd2;
        base = out_wr;
        pulse_start();
        wait_words(base, 10, 200, "t2_wait");
        pulse_stop();
        wait_idle(100, "t2_idle");
        check("t2_count", 64'(out_wr - base), 64'd12);
        for (int k = 0; k < 4; k++) begin
            check("t2_hdr", 64'(word(base, 3 * k)), hdr(1'(k % 2), 16'(k)));
            for (int j = 0; j < 2; j++) begin
                check("t2_sample", 64'(word(base, 3 * k + 1 + j)),
                      smp(j == 1, ((k % 2) == 1 ? 32'h2000_0000 : 32'h1000_0000) +
                          32'((k / 2) * 2 + j)));
            end
        end

        // BurstLen 0 selects the default of 256
        do_reset();
        bus.ChanMask = 2'b01;
        bus.BurstLen = 12'd0;
        base = out_wr;
        r0s = rdy0_cnt;
        pulse_start();
        pulse_stop();
        wait_idle(700, "t3_idle");
        check("t3_count", 64'(out_wr - base), 64'd257);
        check("t3_hdr", 64'(word(base, 0)), hdr(1'b0, 16'd0));
        for (int i = 0; i < 256; i++) begin
            check("t3_sample", 64'(word(base, i + 1)), smp(i == 255, 32'h1000_0000 + 32'(i)));
        end
        check("t3_ready_cycles", 64'(rdy0_cnt - r0s), 64'd256);

        // Downstream stalled: buffer fills, remaining samples dropped
        do_reset();
        bus.ChanMask = 2'b01;
        bus.BurstLen = 12'd8;
        bus.OutReady = 1'b0;
        base = out_wr;
        pulse_start();
        pulse_stop();
        repeat (20) tick();
        check("t4_busy", 64'(bus.Busy), 64'd1);
        check("t4_overrun", 64'(bus.Overrun), 64'd1);
        check("t4_dropcnt", 64'(bus.DropCnt), 64'd5);
        check("t4_head", 64'({bus.OutValid, bus.OutLast, bus.OutDat}), 64'({2'b10, 32'hA500_0000}));
        bus.OutReady = 1'b1;
        wait_idle(50, "t4_idle");
        check("t4_count", 64'(out_wr - base), 64'd4);
        for (int i = 0; i < 3; i++) begin
            check("t4_sample", 64'(word(base, i + 1)), smp(1'b0, 32'h1000_0000 + 32'(i)));
        end
        check("t4_overrun_sticky", 64'({bus.Overrun, bus.DropCnt}), 64'({1'b1, 16'd5}));

        // Stop mid-burst: burst completes, then idle
        do_reset();
        bus.ChanMask = 2'b01;
        bus.BurstLen = 12'd16;
        base = out_wr;
        pulse_start();
        wait_words(base, 6, 100, "t5_wait");
        pulse_stop();
        wait_idle(100, "t5_idle");
        check("t5_count", 64'(out_wr - base), 64'd17);
        for (int i = 0; i < 16; i++) begin
            check("t5_sample", 64'(word(base, i + 1)), smp(i == 15, 32'h1000_0000 + 32'(i)));
        end
        repeat (10) tick();
        check("t5_stays_idle", 64'({bus.Busy, 10'(out_wr - base)}), 64'({1'b0, 10'd17}));

        // Reset mid-burst aborts everything
        do_reset();
        base = out_wr;
        pulse_start();
        wait_words(base, 6, 100, "t6_wait");
        rst = 1'b1;
        tick();
        check("t6_reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        snap = out_wr;
        repeat (10) tick();
        check("t6_no_output", 64'(out_wr - snap), 64'd0);
        check("t6_busy", 64'(bus.Busy), 64'd0);

        // Start ignored with no channel enabled, and when Stop arrives together
        do_reset();
        bus.ChanMask = 2'b00;
        pulse_start();
        tick();
        check("t7_start_mask0", 64'(bus.Busy), 64'd0);
        bus.ChanMask = 2'b01;
        bus.Start = 1'b1;
        bus.Stop = 1'b1;
        tick();
        bus.Start = 1'b0;
        bus.Stop = 1'b0;
        tick();
        check("t7_start_stop", 64'(bus.Busy), 64'd0);

        // Only ch1 enabled, burst of 1: ch1 chosen every time, each sample is Last
        do_reset();
        bus.ChanMask = 2'b10;
        bus.BurstLen = 12'd1;
        base = out_wr;
        r0s = rdy0_cnt;
        r1s = rdy1_cnt;
        pulse_start();
        wait_words(base, 6, 100, "t8_wait");
        pulse_stop();
        wait_idle(100, "t8_idle");
        nw = out_wr - base;
        nb = nw / 2;
        check("t8_even", 64'(nw % 2), 64'd0);
        check("t8_min_bursts", 64'(nb >= 3), 64'd1);
        check("t8_ready_cycles", 64'(rdy1_cnt - r1s), 64'(nb));
        check("t8_ch0_ready", 64'(rdy0_cnt - r0s), 64'd0);
        for (int k = 0; k < int'(nb); k++) begin
            check("t8_hdr", 64'(word(base, 2 * k)), hdr(1'b1, 16'(k)));
            check("t8_sample", 64'(word(base, 2 * k + 1)), smp(1'b1, 32'h2000_0000 + 32'(k)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
